stream_sink_checker: RTL and testbench
======================================

Name: stream_sink_checker

Overview:
- Consumer/responder end of the valid/ready stream interface driven by our `pipeline` stage.
- Accepts words from an upstream `valide_in`/`Datain` source and drives `ready_out` back-pressure from a programmable rotating throttle pattern.
- Checks accepted words against an expected incrementing sequence and checks the upstream hold-while-stalled rule.
- Reports word, error and protocol status; used as the standard end-of-pipe checker in pipeline benches and in loopback self-test.

Parameters:
- bus_width, 4, data word width.
- cnt_width, 8, width of the length, word-count and error-count registers.
- pat_width, 8, width of the ready throttle pattern.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a check run (honoured in IDLE and DONE only).
- exp_base  input  bus_width  first expected data value, sampled on an accepted start.
- exp_len  input  cnt_width  number of words to accept, sampled on an accepted start.
- ready_pattern  input  pat_width  throttle pattern, sampled on an accepted start.
- valide_in  input  1  upstream data valid.
- Datain  input  bus_width  upstream data.
- ready_out  output  1  ready to upstream.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- word_count  output  cnt_width  words accepted this run.
- error_count  output  cnt_width  data mismatches this run; saturates at all-ones.
- first_err_data  output  bus_width  Datain of the first mismatching word.
- protocol_err  output  1  sticky upstream-violation flag.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, ready_out=0, busy=0, done=0, word_count=0, error_count=0, first_err_data=0, protocol_err=0, internal expected/remaining/pattern registers=0. Reset asserted mid-run aborts the run immediately: all outputs return to reset values on the next edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_out=0.
  - On start: load expected=exp_base, remaining=exp_len and pat_reg=ready_pattern; if ready_pattern==0, load all-ones instead (no deadlock).
  - On start: clear word_count, error_count, first_err_data and protocol_err.
  - Next state is RUN, or DONE if exp_len==0.
- RUN:
  - ready_out = pat_reg[0], driven only from registers. There is no combinational path from valide_in or Datain to ready_out.
  - pat_reg rotates right by 1 every cycle, independent of transfers.
  - start is ignored.
- Transfer = valide_in && ready_out at a rising edge. On each transfer:
  - word_count+1.
  - remaining-1.
  - expected = expected+1, wrapping mod 2^bus_width.
  - If Datain != expected: error_count+1 (saturating). If this is the first error of the run (error_count was 0), capture first_err_data=Datain.
- Completion: the transfer that brings remaining to 0 moves the FSM to DONE. ready_out is 0 from the next cycle, so no further words are accepted.
- DONE:
  - done=1 and ready_out=0; counters hold.
  - start behaves exactly as in IDLE (restart).
- Protocol check, active in RUN only:
  - If valide_in=1 and ready_out=0 in cycle N, then cycle N+1 must have valide_in=1 with unchanged Datain. Otherwise protocol_err sets.
  - protocol_err is sticky until reset or the next accepted start.
  - The check is not applied to the cycle after a transfer.
- Latency: status outputs update on the edge of the transfer; done is visible the cycle after the last transfer.
- Counters: word_count is cnt_width and cannot overflow (bounded by exp_len). error_count saturates at 2^cnt_width-1.
- Simultaneous start and reset: reset wins.

Test Plan:
- Clean run: rst 1 cycle; start with exp_base=4'h1, exp_len=5, ready_pattern=8'hFF; upstream holds valide_in=1 and sends 1,2,3,4,5 -> ready_out=1 for 5 cycles, word_count=5, error_count=0, done=1 the cycle after the 5th transfer, ready_out=0 afterwards.
- Throttle and wrap: exp_base=4'hE, exp_len=4, ready_pattern=8'b0000_0101; upstream sends E,F,0,1 and holds each word when stalled -> ready_out toggles per the rotating pattern, exactly 4 transfers, wrap F->0 accepted, error_count=0, protocol_err=0.
- Mismatch: exp_base=1, exp_len=4, data 1,2,7,9 -> error_count=2, first_err_data=4'h7, word_count=4, done=1.
- Protocol violation: ready_pattern=8'h01; while ready_out=0, upstream changes Datain (or drops valide_in) -> protocol_err=1 the next cycle and stays 1 to end of run; a subsequent start clears it.
- Edge cases:
  - exp_len=0 -> DONE the cycle after start, with ready_out never asserted.
  - ready_pattern=0 -> behaves as all-ones.
  - start pulsed during RUN -> ignored.
- Reset mid-run: assert rst after 2 of 5 transfers -> next cycle all outputs are at reset values and state is IDLE; a new start runs normally.

Source files
------------

// File: rtl/stream_sink_checker.sv
// stream_sink_checker
//   End-of-pipe consumer for a valid/ready stream. Throttles the upstream with a
//   rotating ready pattern, checks accepted words against an incrementing
//   expected sequence, and flags upstream words that change or vanish while
//   stalled.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           one-cycle run request, honoured in IDLE and DONE
//   exp_base        first expected word            (sampled on accepted start)
//   exp_len         number of words to accept      (sampled on accepted start)
//   ready_pattern   ready throttle pattern, bit 0 first (sampled on accepted start)
//   valide_in       upstream valid
//   Datain          upstream data
//   ready_out       ready to upstream, registered-only source
//   busy / done     run in progress / run complete
//   word_count      words accepted this run
//   error_count     data mismatches this run, saturating
//   first_err_data  Datain of the first mismatching word
//   protocol_err    sticky hold-while-stalled violation
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, ready_out low
// RUN   | accepting words, ready_out follows the rotating pattern
// DONE  | all words accepted, status held, start restarts a run

module stream_sink_checker #(
    parameter int bus_width = 4,
    parameter int cnt_width = 8,
    parameter int pat_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [bus_width-1:0] exp_base,
    input  logic [cnt_width-1:0] exp_len,
    input  logic [pat_width-1:0] ready_pattern,
    input  logic                 valide_in,
    input  logic [bus_width-1:0] Datain,
    output logic                 ready_out,
    output logic                 busy,
    output logic                 done,
    output logic [cnt_width-1:0] word_count,
    output logic [cnt_width-1:0] error_count,
    output logic [bus_width-1:0] first_err_data,
    output logic                 protocol_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};
    localparam logic [bus_width-1:0] BUS_ONE = {{(bus_width-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [bus_width-1:0] expected_q, expected_d;
    logic [cnt_width-1:0] remaining_q, remaining_d;
    logic [pat_width-1:0] pat_reg_q, pat_reg_d;
    logic [cnt_width-1:0] word_count_q, word_count_d;
    logic [cnt_width-1:0] error_count_q, error_count_d;
    logic [bus_width-1:0] first_err_q, first_err_d;
    logic                 protocol_err_q, protocol_err_d;
    // Last cycle was a stall (valid && !ready) in RUN, and the word held then.
    logic                 stall_q, stall_d;
    logic [bus_width-1:0] hold_data_q, hold_data_d;

    logic ready_int;
    logic xfer;

    // ready depends only on flops: no valid/data path into ready_out.
    assign ready_int = (state_q == ST_RUN) ? pat_reg_q[0] : 1'b0;
    assign xfer      = valide_in && ready_int;

    always_comb begin
        state_d        = state_q;
        expected_d     = expected_q;
        remaining_d    = remaining_q;
        pat_reg_d      = pat_reg_q;
        word_count_d   = word_count_q;
        error_count_d  = error_count_q;
        first_err_d    = first_err_q;
        protocol_err_d = protocol_err_q;
        stall_d        = 1'b0;
        hold_data_d    = hold_data_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    expected_d     = exp_base;
                    remaining_d    = exp_len;
                    // An all-zero pattern would never raise ready; treat it as always-ready.
                    pat_reg_d      = (ready_pattern == '0) ? '1 : ready_pattern;
                    word_count_d   = '0;
                    error_count_d  = '0;
                    first_err_d    = '0;
                    protocol_err_d = 1'b0;
                    state_d        = (exp_len == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                pat_reg_d   = {pat_reg_q[0], pat_reg_q[pat_width-1:1]};
                stall_d     = valide_in && !ready_int;
                hold_data_d = Datain;

                // A stalled word must still be offered, unchanged, the next cycle.
                if (stall_q && (!valide_in || (Datain != hold_data_q))) begin
                    protocol_err_d = 1'b1;
                end

                if (xfer) begin
                    word_count_d = word_count_q + CNT_ONE;
                    remaining_d  = remaining_q - CNT_ONE;
                    expected_d   = expected_q + BUS_ONE;
                    if (Datain != expected_q) begin
                        if (error_count_q != '1) begin
                            error_count_d = error_count_q + CNT_ONE;
                        end
                        if (error_count_q == '0) begin
                            first_err_d = Datain;
                        end
                    end
                    if (remaining_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            expected_q     <= '0;
            remaining_q    <= '0;
            pat_reg_q      <= '0;
            word_count_q   <= '0;
            error_count_q  <= '0;
            first_err_q    <= '0;
            protocol_err_q <= 1'b0;
            stall_q        <= 1'b0;
            hold_data_q    <= '0;
        end else begin
            state_q        <= state_d;
            expected_q     <= expected_d;
            remaining_q    <= remaining_d;
            pat_reg_q      <= pat_reg_d;
            word_count_q   <= word_count_d;
            error_count_q  <= error_count_d;
            first_err_q    <= first_err_d;
            protocol_err_q <= protocol_err_d;
            stall_q        <= stall_d;
            hold_data_q    <= hold_data_d;
        end
    end

    assign ready_out      = ready_int;
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign word_count     = word_count_q;
    assign error_count    = error_count_q;
    assign first_err_data = first_err_q;
    assign protocol_err   = protocol_err_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
module tb_stream_sink_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] exp_base;
    logic [7:0] exp_len;
    logic [7:0] ready_pattern;
    logic       valide_in;
    logic [3:0] Datain;
    logic       ready_out;
    logic       busy;
    logic       done;
    logic [7:0] word_count;
    logic [7:0] error_count;
    logic [3:0] first_err_data;
    logic       protocol_err;

    int n_vec = 0;
    int n_err = 0;

    stream_sink_checker #(
        .bus_width(4),
        .cnt_width(8),
        .pat_width(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .exp_base      (exp_base),
        .exp_len       (exp_len),
        .ready_pattern (ready_pattern),
        .valide_in     (valide_in),
        .Datain        (Datain),
        .ready_out     (ready_out),
        .busy          (busy),
        .done          (done),
        .word_count    (word_count),
        .error_count   (error_count),
        .first_err_data(first_err_data),
        .protocol_err  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ready"}, 32'(ready_out), 0);
        chk({tag, " busy"},  32'(busy), 0);
        chk({tag, " done"},  32'(done), 0);
        chk({tag, " words"}, 32'(word_count), 0);
        chk({tag, " errs"},  32'(error_count), 0);
        chk({tag, " ferr"},  32'(first_err_data), 0);
        chk({tag, " perr"},  32'(protocol_err), 0);
    endtask

    task automatic do_start(input logic [3:0] b, input logic [7:0] l, input logic [7:0] p);
        exp_base      = b;
        exp_len       = l;
        ready_pattern = p;
        start         = 1'b1;
        step();
        start         = 1'b0;
    endtask

    logic [10:0] rdy_seq;
    logic [3:0]  word;
    logic [3:0]  mm_data [4];

    initial begin
        rst = 1'b1; start = 1'b0; exp_base = '0; exp_len = '0; ready_pattern = '0;
        valide_in = 1'b0; Datain = '0;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;

        // Clean run: 1..5, always ready
        do_start(4'h1, 8'd5, 8'hFF);
        chk("clean busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            chk("clean ready", 32'(ready_out), 1);
            valide_in = 1'b1;
            Datain    = 4'(i + 1);
            step();
        end
        valide_in = 1'b0;
        chk("clean done", 32'(done), 1);
        chk("clean words", 32'(word_count), 5);
        chk("clean errs", 32'(error_count), 0);
        chk("clean ready after", 32'(ready_out), 0);
        step();
        chk("clean ready held low", 32'(ready_out), 0);

        // Throttle and wrap: pattern 0000_0101 rotating right, upstream holds when stalled
        rdy_seq = 11'b101_0000_0101;
        word    = 4'hE;
        do_start(4'hE, 8'd4, 8'b0000_0101);
        for (int c = 0; c < 11; c++) begin
            chk("throttle ready", 32'(ready_out), 32'(rdy_seq[c]));
            valide_in = 1'b1;
            Datain    = word;
            step();
            if (rdy_seq[c]) word = word + 4'h1;
        end
        valide_in = 1'b0;
        chk("throttle done", 32'(done), 1);
        chk("throttle words", 32'(word_count), 4);
        chk("throttle errs", 32'(error_count), 0);
        chk("throttle perr", 32'(protocol_err), 0);
        chk("throttle ready after", 32'(ready_out), 0);

        // Mismatch: expect 1,2,3,4 but send 1,2,7,9
        mm_data[0] = 4'h1; mm_data[1] = 4'h2; mm_data[2] = 4'h7; mm_data[3] = 4'h9;
        do_start(4'h1, 8'd4, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            valide_in = 1'b1;
            Datain    = mm_data[i];
            step();
            if (i == 2) begin
                chk("mismatch errs after 3rd", 32'(error_count), 1);
                chk("mismatch ferr after 3rd", 32'(first_err_data), 7);
            end
        end
        valide_in = 1'b0;
        chk("mismatch errs", 32'(error_count), 2);
        chk("mismatch ferr", 32'(first_err_data), 7);
        chk("mismatch words", 32'(word_count), 4);
        chk("mismatch done", 32'(done), 1);

        // Protocol violation: pattern 0x01, data changes while stalled
        do_start(4'h0, 8'd2, 8'h01);
        chk("proto ferr cleared", 32'(first_err_data), 0);
        chk("proto ready c0", 32'(ready_out), 1);
        valide_in = 1'b1; Datain = 4'h0;          // c0: transfer
        step();
        chk("proto ready c1", 32'(ready_out), 0);
        Datain = 4'h1;                            // c1: stall with word 1
        step();
        chk("proto perr before", 32'(protocol_err), 0);
        Datain = 4'h5;                            // c2: word changed while stalled
        step();
        chk("proto perr set", 32'(protocol_err), 1);
        for (int c = 3; c < 8; c++) step();       // hold word 5 through c3..c7
        chk("proto ready c8", 32'(ready_out), 1);
        step();                                   // c8: transfer of 5 (expected 1)
        valide_in = 1'b0;
        chk("proto done", 32'(done), 1);
        chk("proto perr sticky", 32'(protocol_err), 1);
        chk("proto errs", 32'(error_count), 1);
        chk("proto ferr", 32'(first_err_data), 5);

        // Zero-length run: straight to DONE, clears protocol_err
        do_start(4'h3, 8'd0, 8'hFF);
        chk("len0 done", 32'(done), 1);
        chk("len0 busy", 32'(busy), 0);
        chk("len0 ready", 32'(ready_out), 0);
        chk("len0 perr cleared", 32'(protocol_err), 0);
        chk("len0 words", 32'(word_count), 0);
        step();
        chk("len0 ready later", 32'(ready_out), 0);

        // Zero pattern behaves as all-ones; start during RUN ignored
        do_start(4'h3, 8'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("pat0 ready", 32'(ready_out), 1);
            valide_in = 1'b1;
            Datain    = 4'(3 + i);
            if (i == 1) begin
                exp_base = 4'h9; exp_len = 8'd1; ready_pattern = 8'h01; start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        valide_in = 1'b0;
        chk("pat0 done", 32'(done), 1);
        chk("pat0 words", 32'(word_count), 3);
        chk("pat0 errs", 32'(error_count), 0);

        // Reset mid-run after 2 of 5 transfers
        do_start(4'h1, 8'd5, 8'hFF);
        valide_in = 1'b1; Datain = 4'h1; step();
        Datain = 4'h7; step();                    // mismatch so status is non-zero
        chk("midrst words before", 32'(word_count), 2);
        chk("midrst errs before", 32'(error_count), 1);
        Datain = 4'h3; rst = 1'b1; start = 1'b1;  // reset wins over start
        step();
        rst = 1'b0; start = 1'b0; valide_in = 1'b0;
        chk_reset_state("midrst");
        do_start(4'h2, 8'd2, 8'hFF);
        valide_in = 1'b1; Datain = 4'h2; step();
        Datain = 4'h3; step();
        valide_in = 1'b0;
        chk("rerun done", 32'(done), 1);
        chk("rerun words", 32'(word_count), 2);
        chk("rerun errs", 32'(error_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
